// File: rtl/dpram_loader.sv
// dpram_loader: filters the ioctl download stream into one window and turns accepted bytes into RAM write strobes.
// Define DPRAM_LOADER_VERIFY_EN to read each byte back and flag mismatches on verify_err.
module dpram_loader #(
   parameter int          ADDR_WIDTH = 16,
   parameter int          DATA_WIDTH = 8,
   parameter logic [24:0] BASE_ADDR  = 25'd0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  dl_valid,
   input  logic [24:0]           dl_addr,
   input  logic [7:0]            dl_data,
   input  logic                  dl_done,
   output logic                  dl_wait,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_waddr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  busy,
   output logic                  loaded,
   output logic [ADDR_WIDTH:0]   byte_count,
   output logic                  verify_err
);
   typedef enum logic [1:0] {IDLE, WRITE, VRD, VCMP} state_t;
   state_t state, next_state;
   localparam logic [ADDR_WIDTH:0] FULL  = {1'b1, {ADDR_WIDTH{1'b0}}};
   // one extra bit so a window ending at the top of the 25-bit space cannot overflow
   localparam logic [25:0]         LIMIT = {1'b0, BASE_ADDR} + 26'(FULL);
   logic hit, accept;
   assign hit     = (dl_addr >= BASE_ADDR) && ({1'b0, dl_addr} < LIMIT);
   assign accept  = (state == IDLE) && dl_valid && hit;
   assign busy    = state != IDLE;
   assign dl_wait = busy;
   assign ram_we  = state == WRITE;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= next_state;
   always_comb begin
      next_state = state;
`ifdef DPRAM_LOADER_VERIFY_EN
      next_state = state == IDLE  ? (accept ? WRITE : IDLE) :
                   state == WRITE ? VRD :
                   state == VRD   ? VCMP : IDLE;
`else
      next_state = accept ? WRITE : IDLE;
`endif
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ram_waddr  <= '0;
         ram_wdata  <= '0;
         byte_count <= '0;
         loaded     <= 1'b0;
      end else begin
         if (accept) begin
            ram_waddr <= ADDR_WIDTH'(dl_addr - BASE_ADDR);
            ram_wdata <= DATA_WIDTH'(dl_data);
            loaded    <= 1'b0;
         end else if (state == IDLE && dl_done && byte_count != '0)
            loaded <= 1'b1;
         if (state == WRITE && byte_count != FULL)
            byte_count <= byte_count + 1'b1;
      end
`ifdef DPRAM_LOADER_VERIFY_EN
   // VRD held the address, so ram_rdata now shows the byte just written
   always_ff @(posedge clk or posedge reset)
      if (reset)                                       verify_err <= 1'b0;
      else if (state == VCMP && ram_rdata != ram_wdata) verify_err <= 1'b1;
`else
   logic unused_rdata;
   assign unused_rdata = ^ram_rdata;
   assign verify_err   = 1'b0;
`endif
endmodule

// File: tb/tb_dpram_loader.sv
// tb_dpram_loader: directed checks of dpram_loader with a 16-byte window at 0x8000 and a small RAM model.
module tb_dpram_loader;
   logic        clk = 0, reset = 1;
   logic        dl_valid = 0, dl_done = 0;
   logic [24:0] dl_addr = '0;
   logic [7:0]  dl_data = '0;
   logic        dl_wait, ram_we, busy, loaded, verify_err;
   logic [3:0]  ram_waddr;
   logic [7:0]  ram_wdata, ram_rdata = '0;
   logic [4:0]  byte_count;
   logic [7:0]  mem [16];
   logic [11:0] wq [$];
   logic        corrupt = 0;
   int          n_checks = 0, n_fail = 0;
`ifdef DPRAM_LOADER_VERIFY_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   dpram_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .BASE_ADDR(25'h8000)) dut (
      .clk(clk), .reset(reset), .dl_valid(dl_valid), .dl_addr(dl_addr), .dl_data(dl_data),
      .dl_done(dl_done), .dl_wait(dl_wait), .ram_we(ram_we), .ram_waddr(ram_waddr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy), .loaded(loaded),
      .byte_count(byte_count), .verify_err(verify_err));

   always #5 clk = ~clk;

   initial foreach (mem[i]) mem[i] = '0;

   // registered read-before-write RAM; corrupt mode flips the stored byte at address 3
   always @(posedge clk) begin
      ram_rdata <= mem[ram_waddr];
      if (ram_we) begin
         mem[ram_waddr] <= (corrupt && ram_waddr == 4'd3) ? ~ram_wdata : ram_wdata;
         wq.push_back({ram_waddr, ram_wdata});
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // presents a byte with dl_valid left high and returns once the loader is idle again
   task automatic send(input logic [24:0] a, input logic [7:0] d);
      int w;
      logic h;
      h = a >= 25'h8000 && a < 25'h8010;
      dl_addr = a; dl_data = d; dl_valid = 1;
      @(posedge clk); #1;
      check($sformatf("we@%0h", a), ram_we, h);
      if (h) begin
         check($sformatf("waddr@%0h", a), ram_waddr, a[3:0]);
         check($sformatf("wdata@%0h", a), ram_wdata, d);
      end
      w = 0;
      while (dl_wait && w < 10) begin @(posedge clk); #1; w++; end
      check($sformatf("wait@%0h", a), w, h ? LAT : 0);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      tick(2);
      check("rst_we", ram_we, 0);
      check("rst_busy", busy, 0);
      check("rst_wait", dl_wait, 0);
      check("rst_cnt", byte_count, 0);
      check("rst_loaded", loaded, 0);
      check("rst_verr", verify_err, 0);
      check("rst_waddr", ram_waddr, 0);
      check("rst_wdata", ram_wdata, 0);
      reset = 0;
      tick(1);

      // full window with dl_valid held high throughout
      wq.delete();
      for (int i = 0; i < 16; i++) send(25'h8000 + 25'(i), 8'(i) ^ 8'h5A);
      dl_valid = 0;
      tick(1);
      check("sb_n", wq.size(), 16);
      for (int i = 0; i < 16 && i < wq.size(); i++)
         check($sformatf("sb%0d", i), wq[i], {i[3:0], i[7:0] ^ 8'h5A});
      check("cnt16", byte_count, 16);
      check("loaded_pre", loaded, 0);
      dl_done = 1;
      tick(1);
      check("loaded_set", loaded, 1);
      dl_done = 0;
      tick(2);
      check("loaded_hold", loaded, 1);

      // out-of-window bytes are dropped
      send(25'h7FFF, 8'hEE);
      send(25'h8010, 8'hDD);
      dl_valid = 0;
      tick(1);
      check("miss_cnt", byte_count, 16);
      check("miss_loaded", loaded, 1);

      // reset in the middle of a WRITE cycle
      dl_addr = 25'h8005; dl_data = 8'h11; dl_valid = 1;
      tick(1);
      check("mid_we", ram_we, 1);
      reset = 1;
      #1;
      dl_valid = 0;
      check("abort_we", ram_we, 0);
      check("abort_busy", busy, 0);
      check("abort_cnt", byte_count, 0);
      check("abort_loaded", loaded, 0);
      check("abort_waddr", ram_waddr, 0);
      tick(1);
      reset = 0;
      tick(1);

      // reload from zero, then four rewrites to exercise saturation
      send(25'h8000, 8'h5A);
      dl_valid = 0;
      check("cnt_restart", byte_count, 1);
      for (int i = 1; i < 16; i++) send(25'h8000 + 25'(i), 8'(i) ^ 8'h5A);
      dl_valid = 0;
      dl_done = 1;
      tick(1);
      dl_done = 0;
      check("sat_loaded1", loaded, 1);
      send(25'h8000, 8'hA5);
      check("rep_clears", loaded, 0);
      for (int i = 1; i < 4; i++) send(25'h8000 + 25'(i), 8'(i) ^ 8'hA5);
      dl_valid = 0;
      check("sat_cnt", byte_count, 16);
      dl_done = 1;
      tick(1);
      dl_done = 0;
      check("sat_loaded2", loaded, 1);
      check("verr_clean", verify_err, 0);

`ifdef DPRAM_LOADER_VERIFY_EN
      corrupt = 1;
      send(25'h8002, 8'h42);
      check("verr_b2", verify_err, 0);
      send(25'h8003, 8'h43);
      check("verr_b3", verify_err, 1);
      send(25'h8004, 8'h44);
      dl_valid = 0;
      tick(2);
      check("verr_sticky", verify_err, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
